// File: rtl/fx_channel_scheduler_if.sv
// Signal bundle between the per-channel sample sources, the shared datapath and the
// channel scheduler. The scheduler uses the slave view; the environment uses the master view.
interface fx_channel_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 32,
  parameter int CHW    = 2
);
    // Handshake: channel i transfers a sample in any cycle where in_valid[i] & in_ready[i];
    // in_ready is one-hot or zero and never waits on in_valid of the grantee beyond eligibility.
    // out_valid is a single-cycle strobe with no back-pressure.
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    in_valid;
    logic [NUM_CH*DW-1:0] in_data;
    logic [NUM_CH-1:0]    in_ready;
    logic                 ce;
    logic [DW-1:0]        dp_out;
    logic [DW-1:0]        dp_in;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic [DW-1:0]        out_data;
    logic                 busy;
    logic [CHW-1:0]       dbg_ptr;

    modport slave (
        input  ch_en, in_valid, in_data, dp_in,
        output in_ready, ce, dp_out, out_valid, out_ch, out_data, busy, dbg_ptr
    );

    modport master (
        output ch_en, in_valid, in_data, dp_in,
        input  in_ready, ce, dp_out, out_valid, out_ch, out_data, busy, dbg_ptr
    );
endinterface

// File: rtl/fx_channel_scheduler.sv
// Round-robin scheduler sharing one ce-gated datapath across NUM_CH channels; a tag
// pipeline follows each sample through the datapath and labels its result with the channel.
module fx_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DW     = 32,
  parameter int LAT    = 3,
  parameter int CHW    = 2
) (
    input logic                  clk,
    input logic                  rst,
    fx_channel_scheduler_if.slave bus
);
    logic [NUM_CH-1:0] eligible;
    logic              found;
    logic [CHW-1:0]    grant;
    logic              issue;
    logic              ce_int;

    logic [CHW-1:0]    ptr;
    logic [LAT-1:0]    tag_v;
    logic [CHW-1:0]    tag_ch [LAT];
    logic              out_valid_q;
    logic [CHW-1:0]    out_ch_q;
    logic [DW-1:0]     out_data_q;

    // First eligible channel at or after ptr, wrapping modulo NUM_CH.
    always_comb begin
        eligible = bus.in_valid & bus.ch_en;
        found    = 1'b0;
        grant    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && eligible[(int'(ptr) + k) % NUM_CH]) begin
                found = 1'b1;
                grant = CHW'((int'(ptr) + k) % NUM_CH);
            end
        end
    end

    // Reset overrides the grant combinationally so nothing transfers while rst is low.
    assign issue  = found & rst;
    assign ce_int = rst & (issue | (|tag_v));

    always_comb begin
        bus.in_ready = '0;
        bus.dp_out   = '0;
        if (issue) begin
            bus.in_ready[grant] = 1'b1;
            bus.dp_out          = bus.in_data[int'(grant)*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr         <= '0;
            tag_v       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            if (issue) begin
                ptr <= CHW'((int'(grant) + 1) % NUM_CH);
            end
            // Tags advance only with the datapath so tag_v[LAT-1] lines up with dp_in.
            if (ce_int) begin
                for (int k = LAT - 1; k > 0; k--) begin
                    tag_v[k]  <= tag_v[k-1];
                    tag_ch[k] <= tag_ch[k-1];
                end
                tag_v[0]  <= issue;
                tag_ch[0] <= grant;
            end
            out_valid_q <= tag_v[LAT-1];
            if (tag_v[LAT-1]) begin
                out_ch_q   <= tag_ch[LAT-1];
                out_data_q <= bus.dp_in;
            end
        end
    end

    assign bus.ce        = ce_int;
    assign bus.busy      = |tag_v;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.dbg_ptr   = ptr;
endmodule

// File: tb/tb_fx_channel_scheduler.sv
// Bench for fx_channel_scheduler: directed scenarios then random traffic, each cycle
// compared against a latency/queue reference model of the scheduling rules.
module tb_fx_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int LAT    = 3;
  localparam int CHW    = 2;
  localparam int QW     = 32 + 8 + DW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fx_channel_scheduler_if #(.NUM_CH(NUM_CH), .DW(DW), .CHW(CHW)) bus ();

  fx_channel_scheduler #(.NUM_CH(NUM_CH), .DW(DW), .LAT(LAT), .CHW(CHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // datapath stub: LAT-deep ce-gated register chain, identity function
  logic [DW-1:0] dp_pipe [LAT];
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) dp_pipe[k] <= '0;
    end else if (bus.ce) begin
      dp_pipe[0] <= bus.dp_out;
      for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
  end
  assign bus.dp_in = dp_pipe[LAT-1];

  // scoreboard: each entry = {due cycle, channel, data}
  logic [QW-1:0] exp_q[$];
  int            cyc = 0;
  int            m_ptr = 0;
  logic [CHW-1:0] m_och = '0;
  logic [DW-1:0]  m_odata = '0;
  int            n_asserts = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_check();
    logic [NUM_CH-1:0] elig;
    logic              fnd;
    int                g;
    logic [NUM_CH-1:0] e_ready;
    logic [DW-1:0]     e_dp;
    logic              e_ov;
    logic              e_busy;
    elig = bus.in_valid & bus.ch_en;
    fnd  = 1'b0;
    g    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!fnd && elig[(m_ptr + k) % NUM_CH]) begin
        fnd = 1'b1;
        g   = (m_ptr + k) % NUM_CH;
      end
    end
    fnd     = fnd & rst;
    e_ready = fnd ? NUM_CH'(1 << g) : '0;
    e_dp    = fnd ? bus.in_data[g*DW +: DW] : '0;
    e_ov    = 1'b0;
    if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) == cyc) begin
      e_ov    = 1'b1;
      m_och   = CHW'(exp_q[0][DW +: 8]);
      m_odata = exp_q[0][DW-1:0];
      void'(exp_q.pop_front());
    end
    e_busy = 1'b0;
    foreach (exp_q[i]) if (int'(exp_q[i][QW-1 -: 32]) - LAT <= cyc) e_busy = 1'b1;
    chk("in_ready",  64'(bus.in_ready),  64'(e_ready));
    chk("dp_out",    64'(bus.dp_out),    64'(e_dp));
    chk("ce",        64'(bus.ce),        64'(rst & (fnd | e_busy)));
    chk("busy",      64'(bus.busy),      64'(e_busy));
    chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
    chk("out_ch",    64'(bus.out_ch),    64'(m_och));
    chk("out_data",  64'(bus.out_data),  64'(m_odata));
    chk("ptr",       64'(bus.dbg_ptr),   64'(m_ptr));
    if (!rst) begin
      exp_q.delete();
      m_ptr   = 0;
      m_och   = '0;
      m_odata = '0;
    end else if (fnd) begin
      exp_q.push_back({32'(cyc + LAT + 1), 8'(g), e_dp});
      m_ptr = (g + 1) % NUM_CH;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_all_data();
    for (int i = 0; i < NUM_CH; i++) bus.in_data[i*DW +: DW] = $urandom;
  endtask

  initial begin
    bus.ch_en    = '0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    rst          = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    rst = 1'b1;
    bus.ch_en = 4'b1111;
    repeat (2) step();

    // single sample from ch2
    bus.in_valid = 4'b0100;
    bus.in_data[2*DW +: DW] = 32'h0000_1234;
    #1 chk("t1_ready", 64'(bus.in_ready), 64'b0100);
    step();
    bus.in_valid = '0;
    repeat (3) step();
    chk("t1_ov",   64'(bus.out_valid), 64'd1);
    chk("t1_ch",   64'(bus.out_ch),    64'd2);
    chk("t1_data", 64'(bus.out_data),  64'h1234);
    chk("t1_ce",   64'(bus.ce),        64'd0);
    repeat (3) step();

    // all channels continuously valid
    bus.in_valid = 4'b1111;
    repeat (12) begin set_all_data(); step(); end
    // channel 2 disabled
    bus.ch_en = 4'b1011;
    repeat (9) begin set_all_data(); step(); end
    bus.in_valid = '0;
    bus.ch_en = 4'b1111;
    repeat (LAT + 3) step();

    // ptr wrap: move ptr to 3, then ch0 and ch3 compete
    bus.in_valid = 4'b0100;
    step();
    bus.in_valid = 4'b1001;
    set_all_data();
    #1 chk("t5_first", 64'(bus.in_ready), 64'b1000);
    step();
    #1 chk("t5_second", 64'(bus.in_ready), 64'b0001);
    step();
    bus.in_valid = '0;
    repeat (LAT + 3) step();

    // reset mid-flight
    bus.in_valid = 4'b1111;
    set_all_data(); step();
    set_all_data(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.in_valid = '0;
    chk("t4_ptr",  64'(bus.dbg_ptr), 64'd0);
    chk("t4_busy", 64'(bus.busy),    64'd0);
    repeat (LAT + 2) step();
    bus.in_valid = 4'b1111;
    #1 chk("t4_grant", 64'(bus.in_ready), 64'b0001);
    step();
    bus.in_valid = '0;

    // idle
    repeat (LAT + 6) step();

    // random traffic
    repeat (400) begin
      bus.ch_en    = NUM_CH'($urandom | $urandom);
      bus.in_valid = NUM_CH'($urandom_range(0, 15));
      set_all_data();
      rst = ($urandom_range(0, 49) != 0);
      step();
    end
    rst = 1'b1;
    bus.in_valid = '0;
    repeat (LAT + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
